// File: rtl/square_root_module_if.sv
// rtl/square_root_module_if.sv - request/result bundle of the significand square-root unit
interface square_root_module_if #(
  parameter int W = 8
);
  logic         doSqrt_i;
  logic [W-1:0] s_i;
  logic         is_exp_odd_i;
  logic         special_case_i;
  logic [W-1:0] res_o;
  logic         valid_o;

  modport master (
    output doSqrt_i, s_i, is_exp_odd_i, special_case_i,
    input  res_o, valid_o
  );

  modport slave (
    input  doSqrt_i, s_i, is_exp_odd_i, special_case_i,
    output res_o, valid_o
  );
endinterface

// File: rtl/square_root_module.sv
// rtl/square_root_module.sv - restoring significand square root, one root bit per cycle
// Optional SQRT_ROUND_EN: one extra iteration and round-half-up with saturation.
package lampFPU_pkg;
  localparam int LAMP_FLOAT_F_DW = 7;
endpackage

module square_root_module
  import lampFPU_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  square_root_module_if.slave sqrt_if
);
  localparam int W = 1 + LAMP_FLOAT_F_DW;
`ifdef SQRT_ROUND_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif
  localparam int RW = N + 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SPEC} state_t;

  state_t           r_state;
  logic [2*N-1:0]   r_rad;
  logic [RW-1:0]    r_rem;
  logic [N-1:0]     r_root;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_res;
  logic             r_valid;

  logic [2*N-1:0]   w_rad_init;
  logic [RW+1:0]    w_rem_sh;
  logic [RW+1:0]    w_diff;
  logic             w_bit;
  logic [N-1:0]     w_root_next;
  logic [W-1:0]     w_res_final;

  // Odd exponents pre-double the operand, i.e. one extra bit of left shift.
  assign w_rad_init = sqrt_if.is_exp_odd_i ? {sqrt_if.s_i, {(2*N-W){1'b0}}}
                                           : {1'b0, sqrt_if.s_i, {(2*N-W-1){1'b0}}};

  assign w_rem_sh    = {r_rem, r_rad[2*N-1 -: 2]};
  assign w_bit       = (w_rem_sh >= {2'b00, r_root, 2'b01});
  assign w_diff      = w_rem_sh - {2'b00, r_root, 2'b01};
  assign w_root_next = {r_root[N-2:0], w_bit};

`ifdef SQRT_ROUND_EN
  logic [W:0] w_rnd;
  assign w_rnd       = {1'b0, w_root_next[N-1:1]} + {{W{1'b0}}, w_root_next[0]};
  assign w_res_final = w_rnd[W] ? {W{1'b1}} : w_rnd[W-1:0];
`else
  assign w_res_final = w_root_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rad   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sqrt_if.doSqrt_i) begin
            if (sqrt_if.special_case_i) begin
              r_state <= S_SPEC;
            end else begin
              r_rad   <= w_rad_init;
              r_rem   <= '0;
              r_root  <= '0;
              r_cnt   <= '0;
              r_state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          r_rad  <= r_rad << 2;
          r_rem  <= RW'(w_bit ? w_diff : w_rem_sh);
          r_root <= w_root_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1)) begin
            r_res   <= w_res_final;
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_SPEC: begin
          r_res   <= '0;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sqrt_if.res_o   = r_res;
  assign sqrt_if.valid_o = r_valid;
endmodule

// File: tb/tb_square_root_module.sv
// tb/tb_square_root_module.sv - self-checking bench for square_root_module
module tb_square_root_module;
  localparam int W = 8;
`ifdef SQRT_ROUND_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  square_root_module_if #(.W(W)) sif ();

  square_root_module dut (
    .clk     (clk),
    .rst     (rst),
    .sqrt_if (sif)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] ref_sqrt(input logic [W-1:0] s, input bit odd);
    longint r, q, res;
    r = odd ? (longint'(s) << W) : (longint'(s) << (W - 1));
`ifdef SQRT_ROUND_EN
    r = r * 4;
`endif
    q = 0;
    while ((q + 1) * (q + 1) <= r) q++;
`ifdef SQRT_ROUND_EN
    res = (q + 1) / 2;
    if (res > (longint'(1) << W) - 1) res = (longint'(1) << W) - 1;
`else
    res = q;
`endif
    return res[W-1:0];
  endfunction

  task automatic run_op(input logic [W-1:0] s, input bit odd, input bit spec, input bit scramble,
                        output logic [W-1:0] res, output int lat);
    @(negedge clk);
    sif.s_i            = s;
    sif.is_exp_odd_i   = odd;
    sif.special_case_i = spec;
    sif.doSqrt_i       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.doSqrt_i = 1'b0;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 40; i++) begin
      if (scramble) begin
        sif.s_i            = W'($urandom);
        sif.is_exp_odd_i   = 1'($urandom);
        sif.special_case_i = 1'($urandom);
        sif.doSqrt_i       = (i <= LAT - 2) ? 1'($urandom) : 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (sif.valid_o === 1'b1) begin
        lat = i;
        res = sif.res_o;
        break;
      end
    end
    sif.doSqrt_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.doSqrt_i = 1'b0;
    sif.s_i = '0;
    sif.is_exp_odd_i = 1'b0;
    sif.special_case_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sif.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", sif.valid_o);
    end
    checks++;
    if (sif.res_o !== '0) begin
      errors++;
      $display("FAIL reset_res: got %h expected 00", sif.res_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] d_s   [5] = '{8'h80, 8'h80, 8'hFF, 8'h90, 8'hC8};
    bit           d_odd [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef SQRT_ROUND_EN
    logic [W-1:0] d_exp [5] = '{8'h80, 8'hB5, 8'hB5, 8'h88, 8'hE2};
`else
    logic [W-1:0] d_exp [5] = '{8'h80, 8'hB5, 8'hB4, 8'h87, 8'hE2};
`endif
    logic [W-1:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(d_s[i], d_odd[i], 1'b0, 1'b0, res, lat);
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT);
      end
      checks++;
      if (res !== d_exp[i]) begin
        errors++;
        $display("FAIL directed_res[%0d] s=%h odd=%0d: got %h expected %h", i, d_s[i], d_odd[i], res, d_exp[i]);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (sif.valid_o !== 1'b0 || sif.res_o !== d_exp[i]) begin
        errors++;
        $display("FAIL directed_hold[%0d]: got valid=%b res=%h expected valid=0 res=%h", i, sif.valid_o, sif.res_o, d_exp[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [W-1:0] res;
    int lat;
    run_op(8'h00, 1'b1, 1'b1, 1'b0, res, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL special_latency: got %0d expected 1", lat);
    end
    checks++;
    if (res !== 8'h00) begin
      errors++;
      $display("FAIL special_res: got %h expected 00", res);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (sif.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL special_pulse_width: got valid=%b expected 0", sif.valid_o);
    end
  endtask

  task automatic test_hold_inputs();
    logic [W-1:0] s, res, exp_res;
    bit odd;
    int lat;
    for (int n = 0; n < 4; n++) begin
      s = {1'b1, 7'($urandom)};
      odd = 1'($urandom);
      exp_res = ref_sqrt(s, odd);
      run_op(s, odd, 1'b0, 1'b1, res, lat);
      checks++;
      if (lat !== LAT || res !== exp_res) begin
        errors++;
        $display("FAIL hold_inputs s=%h odd=%0d: got res=%h lat=%0d expected res=%h lat=%0d", s, odd, res, lat, exp_res, LAT);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    sif.s_i = 8'hC8;
    sif.is_exp_odd_i = 1'b1;
    sif.special_case_i = 1'b0;
    sif.doSqrt_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.doSqrt_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (sif.valid_o === 1'b1) seen++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (sif.valid_o === 1'b1) seen++;
    checks++;
    if (sif.res_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_res: got %h expected 00", sif.res_o);
    end
    rst = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sif.valid_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_valid: got %0d pulses expected 0", seen);
    end
    checks++;
    if (sif.res_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_res_after: got %h expected 00", sif.res_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    bit oa, ob;
    int pulses = 0;
    a = {1'b1, 7'($urandom)};
    b = {1'b1, 7'($urandom)};
    oa = 1'($urandom);
    ob = 1'($urandom);
    @(negedge clk);
    sif.s_i = a;
    sif.is_exp_odd_i = oa;
    sif.special_case_i = 1'b0;
    sif.doSqrt_i = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 2 * LAT + 5; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) begin
        sif.s_i = b;
        sif.is_exp_odd_i = ob;
      end
      if (e == LAT + 1) sif.doSqrt_i = 1'b0;
      if (sif.valid_o === 1'b1) begin
        pulses++;
        checks++;
        if (pulses == 1) begin
          if (e !== LAT || sif.res_o !== ref_sqrt(a, oa)) begin
            errors++;
            $display("FAIL b2b_first: got edge=%0d res=%h expected edge=%0d res=%h", e, sif.res_o, LAT, ref_sqrt(a, oa));
          end
        end else begin
          if (e !== 2 * LAT + 1 || sif.res_o !== ref_sqrt(b, ob)) begin
            errors++;
            $display("FAIL b2b_pulse%0d: got edge=%0d res=%h expected edge=%0d res=%h", pulses, e, sif.res_o, 2 * LAT + 1, ref_sqrt(b, ob));
          end
        end
      end
    end
    sif.doSqrt_i = 1'b0;
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses expected 2", pulses);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] s, res, exp_res;
    bit odd;
    int lat;
    for (int n = 0; n < 24; n++) begin
      s = {1'b1, 7'($urandom)};
      if (n == 0) s = 8'hFF;
      odd = 1'($urandom);
      exp_res = ref_sqrt(s, odd);
      run_op(s, odd, 1'b0, 1'($urandom), res, lat);
      checks++;
      if (lat !== LAT || res !== exp_res) begin
        errors++;
        $display("FAIL random[%0d] s=%h odd=%0d: got res=%h lat=%0d expected res=%h lat=%0d", n, s, odd, res, lat, exp_res, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_hold_inputs();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
